// File: rtl/diff_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : diff_pkg                                                     |
// | Description : Shared types and constants for the diff_sequencer block and  |
// |               the `different` datapath it drives.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package diff_pkg;

  // Sequencer states; encodings are fixed so external tooling can decode them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } diff_state_e;

  // Default vector geometry, shared with the `different` datapath.
  localparam int DIFF_DATA_SIZE = 16;
  localparam int DIFF_SIZE      = 3;

  // Latency timer width; covers LATENCY values 1..15.
  localparam int TMR_W = 4;

endpackage : diff_pkg
`default_nettype wire

// File: rtl/diff_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : diff_sequencer_if                                            |
// | Description : Control, input-stream, datapath and result-stream signals    |
// |               between the scheduler, diff_sequencer and `different`.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface diff_sequencer_if
  import diff_pkg::*;
#(
  parameter int DATA_SIZE = DIFF_DATA_SIZE,
  parameter int SIZE      = DIFF_SIZE,
  parameter int CNT_W     = 8
);

  localparam int VW = DATA_SIZE * SIZE;

  // Batch control
  logic             start;
  logic [CNT_W-1:0] batch_len;
  logic             abort;
  logic             busy;
  logic             done;

  // Input pair stream
  logic             in_valid;
  logic             in_ready;
  logic [VW-1:0]    in_x;
  logic [VW-1:0]    in_weight;

  // Datapath drive and return
  logic [VW-1:0]    dp_x;
  logic [VW-1:0]    dp_weight;
  logic [VW-1:0]    dp_start_out;
  logic [VW-1:0]    dp_to_all_out;
  logic [VW-1:0]    dp_dense_out;

  // Result stream
  logic             out_valid;
  logic             out_ready;
  logic [VW-1:0]    out_start;
  logic [VW-1:0]    out_to_all;
  logic [VW-1:0]    out_dense;
  logic [CNT_W-1:0] out_index;

  // Sequencer side
  modport slave (
    input  start, batch_len, abort, in_valid, in_x, in_weight,
           dp_start_out, dp_to_all_out, dp_dense_out, out_ready,
    output busy, done, in_ready, dp_x, dp_weight,
           out_valid, out_start, out_to_all, out_dense, out_index
  );

  // Scheduler / producer / consumer / datapath side
  modport master (
    output start, batch_len, abort, in_valid, in_x, in_weight,
           dp_start_out, dp_to_all_out, dp_dense_out, out_ready,
    input  busy, done, in_ready, dp_x, dp_weight,
           out_valid, out_start, out_to_all, out_dense, out_index
  );

endinterface : diff_sequencer_if
`default_nettype wire

// File: rtl/diff_latency_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : diff_latency_timer                                           |
// | Description : Loadable down-counter. zero_o flags that the count reaches 0 |
// |               on the coming edge, so the caller can act on that same edge. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module diff_latency_timer
  import diff_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         load_i,
  input  wire logic [W-1:0] load_val_i,
  input  wire logic         count_i,
  output logic              zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement while counting, saturating at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (count_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Derived from the current count only, keeping load_i out of this path.
  assign zero_o = count_i && (cnt_q <= W'(1));

endmodule : diff_latency_timer
`default_nettype wire

// File: rtl/diff_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : diff_sequencer                                               |
// | Description : Feeds (x, weight) pairs to the `different` datapath one at a |
// |               time, waits its fixed latency and presents the three         |
// |               derivative outputs on a valid/ready result stream.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module diff_sequencer
  import diff_pkg::*;
#(
  parameter int DATA_SIZE = DIFF_DATA_SIZE,
  parameter int SIZE      = DIFF_SIZE,
  parameter int LATENCY   = 1,   // legal range 1..15
  parameter int CNT_W     = 8
) (
  input  wire logic       clk,
  input  wire logic       reset,
  diff_sequencer_if.slave bus
);

  localparam int VW = DATA_SIZE * SIZE;

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_LOAD = 2'(ST_LOAD);
  localparam logic [1:0] S_WAIT = 2'(ST_WAIT);
  localparam logic [1:0] S_HOLD = 2'(ST_HOLD);

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LATENCY);

  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] len_q,       len_d;
  logic [CNT_W-1:0] idx_q,       idx_d;
  logic             done_q,      done_d;
  logic             out_valid_q, out_valid_d;
  logic [VW-1:0]    dp_x_q,      dp_x_d;
  logic [VW-1:0]    dp_w_q,      dp_w_d;
  logic [VW-1:0]    res_s_q,     res_s_d;
  logic [VW-1:0]    res_t_q,     res_t_d;
  logic [VW-1:0]    res_dn_q,    res_dn_d;
  logic [CNT_W-1:0] out_idx_q,   out_idx_d;

  logic w_accept;
  logic w_tmr_zero;

  // Accept only when not being aborted, so an aborted LOAD leaves dp_* untouched.
  assign w_accept = (state_q == S_LOAD) && bus.in_valid && !bus.abort;

  diff_latency_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (w_accept),
    .load_val_i (TMR_LOAD),
    .count_i    (state_q == S_WAIT),
    .zero_o     (w_tmr_zero)
  );

  // Sequencer FSM and result/datapath register next-state.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    dp_x_d      = dp_x_q;
    dp_w_d      = dp_w_q;
    res_s_d     = res_s_q;
    res_t_d     = res_t_q;
    res_dn_d    = res_dn_q;
    out_idx_d   = out_idx_q;

    if (bus.abort) begin
      // Abort beats everything, including a coincident start in IDLE.
      if (state_q != S_IDLE) begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.batch_len != '0) begin
              len_d   = bus.batch_len;
              idx_d   = '0;
              state_d = S_LOAD;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            dp_x_d  = bus.in_x;
            dp_w_d  = bus.in_weight;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_tmr_zero) begin
            res_s_d     = bus.dp_start_out;
            res_t_d     = bus.dp_to_all_out;
            res_dn_d    = bus.dp_dense_out;
            out_idx_d   = idx_q;
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            if (idx_q == (len_q - CNT_W'(1))) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + CNT_W'(1);
              state_d = S_LOAD;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, control and data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      dp_x_q      <= '0;
      dp_w_q      <= '0;
      res_s_q     <= '0;
      res_t_q     <= '0;
      res_dn_q    <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      dp_x_q      <= dp_x_d;
      dp_w_q      <= dp_w_d;
      res_s_q     <= res_s_d;
      res_t_q     <= res_t_d;
      res_dn_q    <= res_dn_d;
      out_idx_q   <= out_idx_d;
    end
  end

  // Outputs are registers or decodes of the registered state only.
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.in_ready   = (state_q == S_LOAD);
  assign bus.done       = done_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.dp_x       = dp_x_q;
  assign bus.dp_weight  = dp_w_q;
  assign bus.out_start  = res_s_q;
  assign bus.out_to_all = res_t_q;
  assign bus.out_dense  = res_dn_q;
  assign bus.out_index  = out_idx_q;

endmodule : diff_sequencer
`default_nettype wire

// File: tb/tb_diff_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_diff_sequencer                                            |
// | Description : Scoreboard bench for diff_sequencer with a one-register-stage |
// |               stand-in for the `different` datapath (LATENCY = 2).         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_diff_sequencer;
  import diff_pkg::*;

  localparam int DS  = 16;
  localparam int SZ  = 3;
  localparam int LAT = 2;
  localparam int CW  = 8;
  localparam int VW  = DS * SZ;

  typedef struct packed {
    logic [CW-1:0] idx;
    logic [VW-1:0] s;
    logic [VW-1:0] t;
    logic [VW-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  diff_sequencer_if #(.DATA_SIZE(DS), .SIZE(SZ), .CNT_W(CW)) bus ();

  diff_sequencer #(
    .DATA_SIZE (DS),
    .SIZE      (SZ),
    .LATENCY   (LAT),
    .CNT_W     (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Datapath stand-in: element-wise product, sum and xor.
  function automatic logic [VW-1:0] f_mul(input logic [VW-1:0] x, input logic [VW-1:0] w);
    logic [VW-1:0] r;
    for (int i = 0; i < SZ; i++) r[i*DS +: DS] = x[i*DS +: DS] * w[i*DS +: DS];
    return r;
  endfunction
  function automatic logic [VW-1:0] f_add(input logic [VW-1:0] x, input logic [VW-1:0] w);
    logic [VW-1:0] r;
    for (int i = 0; i < SZ; i++) r[i*DS +: DS] = x[i*DS +: DS] + w[i*DS +: DS];
    return r;
  endfunction

  // One register stage plus the capture edge gives LATENCY = 2.
  logic [VW-1:0] dp_s_r, dp_t_r, dp_d_r;
  always @(posedge clk) begin
    dp_s_r <= f_mul(bus.dp_x, bus.dp_weight);
    dp_t_r <= f_add(bus.dp_x, bus.dp_weight);
    dp_d_r <= bus.dp_x ^ bus.dp_weight;
  end
  assign bus.dp_start_out  = dp_s_r;
  assign bus.dp_to_all_out = dp_t_r;
  assign bus.dp_dense_out  = dp_d_r;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor / scoreboard state
  exp_t          sb[$];
  exp_t          e;
  int            cyc       = 0;
  int            acc_edge  = -100;
  int            prev_acc  = -100;
  int            acc_cnt   = 0;
  int            pops      = 0;
  int            done_cnt  = 0;
  int            busy_cnt  = 0;
  logic          acc_flag  = 1'b0;
  logic          tput      = 1'b0;
  logic          m_busy    = 1'b0;
  logic          exp_done  = 1'b0;
  logic [CW-1:0] m_len     = '0;
  logic [CW-1:0] m_acc_idx = '0;
  logic [VW-1:0] acc_x, acc_w;
  logic          prev_ov   = 1'b0;
  logic          prev_hs   = 1'b0;
  logic [VW-1:0] prev_s, prev_t, prev_d;
  logic [CW-1:0] prev_idx;
  logic          hs, dn_n, busy_now;

  always @(posedge clk) cyc <= cyc + 1;

  // Checks the current cycle, then advances the reference model using the
  // inputs that the coming edge will sample.
  always @(negedge clk) begin
    check("done", 64'(bus.done), 64'(exp_done));
    check("busy", 64'(bus.busy), 64'(m_busy));
    if (bus.done) done_cnt++;
    if (bus.busy) busy_cnt++;
    if (bus.out_valid) check("in_ready_in_hold", 64'(bus.in_ready), 64'd0);
    if (bus.out_valid && prev_ov && !prev_hs) begin
      check("hold_start",  64'(bus.out_start),  64'(prev_s));
      check("hold_to_all", 64'(bus.out_to_all), 64'(prev_t));
      check("hold_dense",  64'(bus.out_dense),  64'(prev_d));
      check("hold_index",  64'(bus.out_index),  64'(prev_idx));
    end
    if (bus.out_valid && !prev_ov) check("latency", 64'(cyc - acc_edge), 64'(LAT));
    if (cyc == acc_edge) begin
      check("dp_x",      64'(bus.dp_x),      64'(acc_x));
      check("dp_weight", 64'(bus.dp_weight), 64'(acc_w));
    end

    hs       = 1'b0;
    dn_n     = 1'b0;
    acc_flag = 1'b0;
    busy_now = m_busy;
    if (reset) begin
      m_busy   = 1'b0;
      acc_edge = -100;
      sb.delete();
    end else if (bus.abort) begin
      if (busy_now) begin
        m_busy = 1'b0;
        sb.delete();
      end
    end else begin
      if (busy_now && bus.out_valid && bus.out_ready) begin
        hs = 1'b1;
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(bus.out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          pops++;
          check("out_index",  64'(bus.out_index),  64'(e.idx));
          check("out_start",  64'(bus.out_start),  64'(e.s));
          check("out_to_all", 64'(bus.out_to_all), 64'(e.t));
          check("out_dense",  64'(bus.out_dense),  64'(e.d));
          if (e.idx == m_len - CW'(1)) begin
            dn_n   = 1'b1;
            m_busy = 1'b0;
          end
        end
      end
      if (busy_now && bus.in_valid && bus.in_ready) begin
        acc_flag = 1'b1;
        acc_edge = cyc + 1;
        acc_x    = bus.in_x;
        acc_w    = bus.in_weight;
        if (tput && m_acc_idx != '0) check("accept_period", 64'(acc_edge - prev_acc), 64'(LAT + 2));
        prev_acc = acc_edge;
        sb.push_back('{idx: m_acc_idx, s: f_mul(bus.in_x, bus.in_weight),
                       t: f_add(bus.in_x, bus.in_weight), d: bus.in_x ^ bus.in_weight});
        m_acc_idx = m_acc_idx + CW'(1);
        acc_cnt++;
      end
      if (!busy_now && bus.start) begin
        if (bus.batch_len == '0) begin
          dn_n = 1'b1;
        end else begin
          m_busy    = 1'b1;
          m_len     = bus.batch_len;
          m_acc_idx = '0;
          busy_cnt  = 0;
        end
      end
    end
    exp_done = dn_n;
    prev_ov  = bus.out_valid;
    prev_hs  = hs;
    prev_s   = bus.out_start;
    prev_t   = bus.out_to_all;
    prev_d   = bus.out_dense;
    prev_idx = bus.out_index;
  end

  // New random pair after every accepted one.
  always @(posedge clk) begin
    #1;
    if (acc_flag) begin
      bus.in_x      = VW'({$urandom(), $urandom()});
      bus.in_weight = VW'({$urandom(), $urandom()});
    end
  end

  task automatic start_batch(input logic [CW-1:0] len);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.batch_len = len;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (!bus.done && n < maxc) begin @(negedge clk); n++; end
    if (!bus.done) check("timeout_done", 64'(bus.done), 64'd1);
  endtask

  task automatic wait_pops(input int target, input int maxc);
    int n = 0;
    while (pops < target && n < maxc) begin @(negedge clk); n++; end
    if (pops < target) check("timeout_pops", 64'(pops), 64'(target));
  endtask

  task automatic wait_acc(input int target, input int maxc);
    int n = 0;
    while (acc_cnt < target && n < maxc) begin @(negedge clk); n++; end
    if (acc_cnt < target) check("timeout_accept", 64'(acc_cnt), 64'(target));
  endtask

  task automatic wait_ov(input int maxc);
    int n = 0;
    while (!bus.out_valid && n < maxc) begin @(negedge clk); n++; end
    if (!bus.out_valid) check("timeout_out_valid", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic check_all_zero(input string ph);
    check({ph, "_busy"},      64'(bus.busy),      64'd0);
    check({ph, "_done"},      64'(bus.done),      64'd0);
    check({ph, "_in_ready"},  64'(bus.in_ready),  64'd0);
    check({ph, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({ph, "_dp_x"},      64'(bus.dp_x),      64'd0);
    check({ph, "_dp_weight"}, 64'(bus.dp_weight), 64'd0);
    check({ph, "_out_start"}, 64'(bus.out_start), 64'd0);
    check({ph, "_out_to_all"},64'(bus.out_to_all),64'd0);
    check({ph, "_out_dense"}, 64'(bus.out_dense), 64'd0);
    check({ph, "_out_index"}, 64'(bus.out_index), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int base_p, base_d, base_a;

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.batch_len = '0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_x      = {16'd3, 16'd5, 16'd7};
    bus.in_weight = {16'd1, 16'd2, 16'd4};
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("init");
    reset        = 1'b0;
    bus.in_valid = 1'b1;

    // Single item with the reference vectors
    base_p = pops; base_d = done_cnt;
    start_batch(8'd1);
    wait_done(50);
    repeat (3) @(negedge clk);
    check("single_pops", 64'(pops - base_p), 64'd1);
    check("single_done_once", 64'(done_cnt - base_d), 64'd1);
    check("single_out_start", 64'(bus.out_start), 64'({16'd3, 16'd10, 16'd28}));

    // Back-pressure on item 1
    base_p = pops; base_d = done_cnt;
    start_batch(8'd3);
    wait_pops(base_p + 1, 50);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    wait_ov(50);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done(100);
    repeat (2) @(negedge clk);
    check("bp_pops", 64'(pops - base_p), 64'd3);
    check("bp_done_once", 64'(done_cnt - base_d), 64'd1);

    // Throughput
    base_p = pops;
    tput = 1'b1;
    start_batch(8'd4);
    wait_done(100);
    check("tput_busy_cycles", 64'(busy_cnt), 64'd16);
    check("tput_pops", 64'(pops - base_p), 64'd4);
    tput = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-length batch
    start_batch(8'd0);
    check("zero_done", 64'(bus.done), 64'd1);
    check("zero_busy", 64'(bus.busy), 64'd0);
    repeat (3) @(negedge clk);

    // Start during WAIT is ignored
    base_p = pops; base_d = done_cnt; base_a = acc_cnt;
    start_batch(8'd2);
    wait_acc(base_a + 1, 50);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.batch_len = 8'd5;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    wait_done(100);
    repeat (8) @(negedge clk);
    check("ign_pops", 64'(pops - base_p), 64'd2);
    check("ign_done_once", 64'(done_cnt - base_d), 64'd1);

    // Abort while holding item 1
    base_p = pops; base_d = done_cnt;
    start_batch(8'd3);
    wait_pops(base_p + 1, 50);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    wait_ov(50);
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    repeat (4) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - base_d), 64'd0);
    bus.out_ready = 1'b1;
    base_p = pops;
    start_batch(8'd1);
    wait_done(50);
    check("post_abort_pops", 64'(pops - base_p), 64'd1);
    repeat (2) @(negedge clk);

    // Reset mid-batch
    base_a = acc_cnt;
    start_batch(8'd3);
    wait_acc(base_a + 1, 50);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("post_reset");
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_diff_sequencer
`default_nettype wire

// File: doc/diff_sequencer.md
# diff_sequencer

Controller that sequences the `different` derivative datapath over a batch of (x, weight) vector pairs. Accepts vector pairs on a valid/ready input stream and drives them onto the datapath's `x`/`weight` inputs. Waits the datapath's fixed latency, then captures all three derivative outputs into a result register held under a valid/ready output handshake. Sits between the training-loop scheduler (start/done) and the `different` instance, which is instantiated beside it, not inside it.

## Interface
- DATA_SIZE, 16, bits per vector element
- SIZE, 3, elements per vector; vector width VW = SIZE*DATA_SIZE
- LATENCY, 1, clk cycles from a `dp_x`/`dp_weight` update to valid datapath outputs; legal range 1..15
- CNT_W, 8, width of batch length and item index
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a batch (sampled only in IDLE)
- batch_len  in  CNT_W  number of items in the batch, sampled with `start`
- abort  in  1  synchronous cancel of the current batch
- busy  out  1  high in LOAD, WAIT and HOLD
- done  out  1  one-cycle pulse at batch completion
- in_valid  in  1  input pair valid
- in_ready  out  1  input pair accepted this cycle when high together with `in_valid`
- in_x, in_weight  in  VW each  input vectors; element 0 in the MSBs [VW-1 -: DATA_SIZE]
- dp_x, dp_weight  out  VW each  registered drive to the datapath `x`/`weight`
- dp_start_out, dp_to_all_out, dp_dense_out  in  VW each  datapath outputs
- out_valid  in/out: out  1  result valid
- out_ready  in  1  downstream accepts result
- out_start, out_to_all, out_dense  out  VW each  captured datapath outputs
- out_index  out  CNT_W  0-based index of the item in `out_*`

## Operation
- FSM states: IDLE, LOAD, WAIT, HOLD.
- **IDLE**
  - `start`=1 with `batch_len`≠0: latch `batch_len`, clear the index, go to LOAD.
  - `start`=1 with `batch_len`=0: pulse `done` on the next cycle and stay in IDLE.
- **LOAD**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: register `in_x`→`dp_x` and `in_weight`→`dp_weight`, load the timer with LATENCY, go to WAIT.
- **WAIT**
  - `in_ready`=0; the timer decrements each cycle.
  - On the edge where the timer reaches 0:
    - capture `dp_*_out` into `out_*`;
    - set `out_index` = current index;
    - set `out_valid`=1;
    - go to HOLD.
- **HOLD**
  - Hold `out_*` stable until `out_valid`&&`out_ready`.
  - On that handshake, clear `out_valid`.
    - If index = latched_len−1: go to IDLE and pulse `done` the next cycle.
    - Otherwise: increment the index and go to LOAD.
- **`dp_x`/`dp_weight`**: hold their last value between items and after a batch. Only reset clears them.
- **`abort`**
  - Any state except IDLE → IDLE on the next edge.
  - Clears `out_valid`; no `done` pulse; `dp_*` retained.
  - `abort` and `start` in the same cycle: abort wins and the batch does not start.
- **Ignored inputs**
  - `start` while busy is ignored.
  - `in_valid` outside LOAD is ignored; no data is lost because `in_ready` is 0.
- **Reset values**:
  - outputs: `in_ready`, `busy`, `done`, `out_valid` = 0; `dp_*`, `out_*`, `out_index` = 0;
  - internal: state = IDLE; timer = 0; latched length = 0.
- No arithmetic on data. Index and latched length are CNT_W unsigned; the index never wraps because it stops at latched_len−1.

## Timing
- Input accepted at edge E0 → `dp_x` valid after E0.
- `out_*`/`out_valid` are registered at edge E0+LATENCY.
- Earliest next accept is at E0+LATENCY+2, with `out_ready` and `in_valid` held high. Steady-state period is LATENCY+2 cycles per item.
- `done` rises one cycle after the final output handshake, lasts one cycle, and coincides with `busy`=0.
- `in_ready` is a registered state decode; there is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Package `diff_pkg` holds:
  - the state enum: IDLE=2'd0, LOAD=2'd1, WAIT=2'd2, HOLD=2'd3;
  - default DATA_SIZE and SIZE constants, shared with `different`;
  - the timer width constant (4 bits).
- Sub-module `diff_latency_timer`: loadable down-counter with a `load` input, a `count` input and a `zero` flag. The FSM and result registers stay in `diff_sequencer`.

## Test plan
All scenarios use LATENCY=2 and a `different` instance connected on the `dp_*` ports.

1. **Reset**: assert `reset` for 3 cycles mid-batch → on the following cycle every output is 0 and state is IDLE.
2. **Single item**
   - Stimulus: `start`, `batch_len`=1, x={16'd3,16'd5,16'd7}, w={16'd1,16'd2,16'd4}; `out_ready` held at 1.
   - Response: `dp_x` equals x one edge after accept; `out_valid` rises 2 cycles after accept; `out_index`=0; `done` pulses exactly once, one cycle after the handshake.
3. **Back-pressure**: `batch_len`=3 with `out_ready` low for 5 cycles on item 1 → `out_*` stable throughout, `in_ready`=0, no item skipped; `out_index` sequence is 0,1,2.
4. **Throughput**: `batch_len`=4, `in_valid` and `out_ready` always high → accepts exactly 4 cycles apart; `done` 1 cycle after the 4th handshake; `busy` high for exactly 16 cycles.
5. **Zero batch and ignored start**
   - `start` with `batch_len`=0 → `done` on the next cycle, `busy` never rises.
   - `start` asserted during WAIT → no effect on the running batch.
6. **Abort**: `batch_len`=3, `abort` asserted while in HOLD on item 1 → next cycle IDLE with `out_valid`=0, no `done`; a following `start` with `batch_len`=1 runs normally from index 0.
